alu_arbiter: RTL

Two-requester scheduler for the shared 16-bit combinational ALU (add, sub, set-less-than, or, and, shift-left). It accepts operation requests from two clients over valid/ready handshakes, grants the ALU round-robin, and drives operands and opcode onto the ALU. It registers the ALU result and returns it to the originating client over a valid/ready response channel. The block sits between the decode/issue logic and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Schedules two requesters onto one shared combinational ALU.
// A request is accepted over a valid/ready handshake. Round-robin
// arbitration picks the requester when both are valid. The operands are
// held in registers that drive the ALU directly. The ALU result is
// registered and returned to the requester that issued the operation,
// over a valid/ready response channel.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/_ready     request handshake (ready is combinational)
//   req{0,1}_opc/_a/_b        opcode and operands
//   rsp{0,1}_valid/_ready     response handshake
//   rsp{0,1}_data/_err        registered result, undefined-opcode flag
//   alu_a, alu_b, alu_opc     registered operands/opcode to the ALU
//   alu_res                   combinational result from the ALU
//   busy                      operation in flight (EXEC or RESP)
module alu_arbiter #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_opc,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_opc,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opc,
    input  logic [WIDTH-1:0] alu_res,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             ptr_r;        // last granted requester
    logic             owner_r;      // requester of the operation in flight
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [OPW-1:0]   opc_r;
    logic [WIDTH-1:0] res_r;
    logic             err_r;
    logic             rsp0_valid_r;
    logic             rsp1_valid_r;
    logic             grant_s;
    logic             accept_s;
    logic             rsp_done_s;

    // Opcodes above shift-left (5) are not ALU operations.
    function automatic logic opc_undefined(input logic [OPW-1:0] opc);
        return (opc > OPW'(3'd5));
    endfunction

    // Arbitration, next-state decode and response completion.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        accept_s     = 1'b0;
        rsp_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                // On a tie the requester that was not granted last wins.
                if (req0_valid && req1_valid) begin
                    grant_s = ~ptr_r;
                end else if (req1_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                accept_s = req0_valid | req1_valid;
                if (accept_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                state_next_s = RESP;
            end
            RESP: begin
                rsp_done_s = owner_r ? rsp1_ready : rsp0_ready;
                if (rsp_done_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // The state register reads IDLE during reset, so ready is masked by rst explicitly.
    assign req0_ready = accept_s & ~grant_s & ~rst;
    assign req1_ready = accept_s &  grant_s & ~rst;

    // State, operand, result and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            ptr_r        <= 1'b1;
            owner_r      <= 1'b0;
            opa_r        <= '0;
            opb_r        <= '0;
            opc_r        <= '0;
            res_r        <= '0;
            err_r        <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        owner_r <= grant_s;
                        ptr_r   <= grant_s;
                        opc_r   <= grant_s ? req1_opc : req0_opc;
                        opa_r   <= grant_s ? req1_a   : req0_a;
                        opb_r   <= grant_s ? req1_b   : req0_b;
                    end
                end
                EXEC: begin
                    res_r        <= alu_res;
                    err_r        <= opc_undefined(opc_r);
                    rsp0_valid_r <= ~owner_r;
                    rsp1_valid_r <= owner_r;
                end
                RESP: begin
                    if (rsp_done_s) begin
                        rsp0_valid_r <= 1'b0;
                        rsp1_valid_r <= 1'b0;
                    end
                end
                default: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // The operand registers feed the ALU directly, so its inputs only change on a grant.
    assign alu_a      = opa_r;
    assign alu_b      = opb_r;
    assign alu_opc    = opc_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp0_data  = res_r;
    assign rsp1_data  = res_r;
    assign rsp0_err   = err_r;
    assign rsp1_err   = err_r;
    assign busy       = (state_r != IDLE);

endmodule
